prog_downcnt: RTL and testbench
===============================

PROG_DOWNCNT -- requirements
Module: prog_downcnt

Interface
REQ-001 The block SHALL have parameter NBITS, default 4: width of the count and load value.
REQ-002 The block SHALL have parameter RELOAD_DEF, default 15: reload value held after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable; the block decrements only when en is high.
REQ-006 The block SHALL have port load, input, 1 bit: load strobe; captures load_val and starts a run.
REQ-007 The block SHALL have port load_val, input, NBITS bits: start and reload value.
REQ-008 The block SHALL have port auto_rl, input, 1 bit: 1 = auto-reload mode, 0 = one-shot mode; sampled at each terminal event.
REQ-009 The block SHALL have port count, output, NBITS bits: the current count, registered.
REQ-010 The block SHALL have port tc, output, 1 bit: terminal-count pulse, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and HOLD.
REQ-013 On load=1 in any state, the block SHALL set count<=load_val and reload_reg<=load_val and enter RUN, regardless of en.
REQ-014 load SHALL take priority over decrement and terminal handling in the same cycle.
REQ-015 In RUN with en=1 and count!=0, the block SHALL set count<=count-1.
REQ-016 In RUN with en=1 and count==0 (the terminal event), the block SHALL set tc<=1 on that edge, so tc is high for exactly one cycle.
REQ-017 At a terminal event with auto_rl=1, the block SHALL set count<=reload_reg and stay in RUN.
REQ-018 At a terminal event with auto_rl=0, count SHALL stay 0 and the block SHALL enter HOLD.
REQ-019 tc SHALL be 0 in every cycle that does not follow a terminal event.
REQ-020 A load in the same cycle as a would-be terminal event SHALL suppress tc.
REQ-021 With en=0, count, state and reload_reg SHALL hold, and tc SHALL be 0.
REQ-022 In IDLE and HOLD, count SHALL hold and en SHALL be ignored; only load leaves these states.
REQ-023 A load with load_val=0 SHALL produce a terminal event on the first subsequent enabled cycle.
REQ-024 The period in auto-reload mode SHALL be reload_reg+1 enabled cycles.
REQ-025 The decrement SHALL be modulo 2^NBITS; wrap below zero SHALL never occur, because zero is the terminal event.
REQ-026 busy SHALL be combinational from the state register: 1 if and only if the state is RUN.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set count<=0, tc<=0, state<=IDLE and reload_reg<=RELOAD_DEF.
REQ-028 rst SHALL take priority over load and en.
REQ-029 rst asserted mid-run SHALL abort the run, with no tc in the following cycle.
REQ-030 After rst is released, the block SHALL stay in IDLE until a load occurs.

Structure
REQ-031 A shared package SHALL hold the state encoding constants (IDLE=2'd0, RUN=2'd1, HOLD=2'd2) and the default NBITS.
REQ-032 The design SHALL be a single module with no sub-modules, containing one state register, count, reload_reg and a tc flop.

Verification
REQ-033 Reset then load_val=3, auto_rl=0, en=1 -> count 3,2,1,0; tc high one cycle after count=0 is sampled; then HOLD with busy=0 and count=0.
REQ-034 load_val=2, auto_rl=1, en=1 for 9 cycles -> count 2,1,0,2,1,0,2,1,0; tc pulses every 3rd cycle.
REQ-035 load_val=5 with en toggling 1,0,1,0 -> count decrements only on en=1 edges; tc stays 0.
REQ-036 load_val=0, en=1 -> tc in the cycle after the first enabled edge; one-shot -> HOLD.
REQ-037 count=0 in RUN with load=1 and load_val=7 in the same cycle -> count=7, tc=0, busy=1.
REQ-038 rst=1 at count=4 in RUN -> next cycle count=0, tc=0, busy=0; en alone does not restart the block.

Source files
------------

// File: rtl/prog_downcnt_pkg.sv
// Shared definitions for the programmable down-counter: state encoding and
// the default counter width.
package prog_downcnt_pkg;

  // Default width of count and load value.
  localparam int NBITS_DEF = 4;

  // Controller states. Encoding is fixed so external checkers can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // True when a state value is one of the legal encodings.
  function automatic logic state_is_legal(input state_t s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/prog_downcnt.sv
// Programmable down-counter with one-shot and auto-reload modes.
//
// A load captures load_val into both the live count and the reload register
// and starts a run. While running, each enabled cycle decrements the count;
// an enabled cycle that finds the count already at zero is the terminal
// event: tc pulses for one cycle, and the counter either reloads (auto_rl=1)
// or parks at zero in HOLD (auto_rl=0). Load beats every other action, and
// reset beats load. Because zero is always the terminal event, the
// decrement never wraps.
module prog_downcnt
  import prog_downcnt_pkg::*;
#(
  parameter int NBITS      = NBITS_DEF,
  parameter int RELOAD_DEF = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             auto_rl,
  output logic [NBITS-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_t           state;
  state_t           next_state;
  logic [NBITS-1:0] reload_reg;
  logic [NBITS-1:0] next_count;
  logic [NBITS-1:0] next_reload;
  logic             next_tc;
  logic             terminal;

  // A terminal event is an enabled RUN cycle that finds the count at zero.
  // It is only acted on when no load arrives in the same cycle.
  assign terminal = (state == ST_RUN) && en && (count == '0);

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= NBITS'(RELOAD_DEF);
      tc         <= 1'b0;
    end else begin
      state      <= next_state;
      count      <= next_count;
      reload_reg <= next_reload;
      tc         <= next_tc;
    end
  end

  // Next-state and next-datapath decode: load first, then run-mode counting.
  always_comb begin
    next_state  = state;
    next_count  = count;
    next_reload = reload_reg;
    next_tc     = 1'b0;
    if (load) begin
      // Load restarts from any state and ignores en; it also masks any
      // terminal event that would have happened this cycle.
      next_count  = load_val;
      next_reload = load_val;
      next_state  = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (terminal) begin
            next_tc = 1'b1;
            if (auto_rl) begin
              next_count = reload_reg;
            end else begin
              next_state = ST_HOLD;
            end
          end else if (en) begin
            next_count = count - NBITS'(1);
          end
        end
        ST_IDLE, ST_HOLD: begin
          // Parked: only a load (handled above) leaves these states.
          next_state = state;
        end
        default: begin
          // Unused encoding: recover to IDLE.
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy = (state == ST_RUN) && state_is_legal(state);
  end

endmodule

// File: tb/tb_prog_downcnt.sv
// Self-checking bench for prog_downcnt: directed scenarios with literal
// expectations, then randomized traffic against a cycle-count reference.
module tb_prog_downcnt;

  localparam int NB  = 4;
  localparam int RLD = 15;

  // Clock / reset block
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [NB-1:0] load_val = '0;
  logic          auto_rl = 1'b0;
  logic [NB-1:0] count;
  logic          tc;
  logic          busy;

  always #5 clk = ~clk;

  prog_downcnt #(.NBITS(NB), .RELOAD_DEF(RLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .auto_rl  (auto_rl),
    .count    (count),
    .tc       (tc),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a run is described by its reload value and the number
  // of enabled cycles since the last load. Inside a run the count is
  // rl - (k mod (rl+1)); outside a run (after reset or in HOLD) it is 0.
  bit m_running = 1'b0;
  int m_rl      = RLD;
  int m_k       = 0;
  bit m_tc      = 1'b0;

  function automatic int model_count();
    return m_running ? (m_rl - (m_k % (m_rl + 1))) : 0;
  endfunction

  function automatic void model_edge();
    m_tc = 1'b0;
    if (rst) begin
      m_running = 1'b0;
      m_rl      = RLD;
      m_k       = 0;
    end else if (load) begin
      m_running = 1'b1;
      m_rl      = int'(load_val);
      m_k       = 0;
    end else if (m_running && en) begin
      if (model_count() == 0) begin
        m_tc = 1'b1;
        if (!auto_rl) m_running = 1'b0;
      end
      m_k++;
    end
  endfunction

  // Driver: one clock edge; the model sees the same inputs the DUT sampled,
  // and outputs settle 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd9;
    step();
    step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (tc !== 1'b0)    begin bad++; $display("FAIL reset_tc got=%0b exp=0", tc); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rst = 1'b0; load = 1'b0; en = 1'b1;
    step();
    total++; if (busy !== 1'b0 || count !== 4'd0) begin
      bad++; $display("FAIL idle_after_reset busy=%0b count=%0d exp busy=0 count=0", busy, count);
    end
  endtask

  task automatic test_oneshot();
    int ec[6] = '{3, 2, 1, 0, 0, 0};
    bit et[6] = '{0, 0, 0, 0, 1, 0};
    bit eb[6] = '{1, 1, 1, 1, 0, 0};
    load = 1'b1; load_val = 4'd3; auto_rl = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      load = 1'b0;
      total++; if (count !== NB'(ec[i]) || tc !== et[i] || busy !== eb[i]) begin
        bad++; $display("FAIL oneshot[%0d] count=%0d tc=%0b busy=%0b exp count=%0d tc=%0b busy=%0b",
                        i, count, tc, busy, ec[i], et[i], eb[i]);
      end
    end
  endtask

  task automatic test_autoreload();
    load = 1'b1; load_val = 4'd2; auto_rl = 1'b1; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      load = 1'b0;
      total++; if (count !== NB'(2 - (i % 3)) || tc !== (i > 0 && i % 3 == 0) || busy !== 1'b1) begin
        bad++; $display("FAIL autoreload[%0d] count=%0d tc=%0b busy=%0b exp count=%0d tc=%0b busy=1",
                        i, count, tc, busy, 2 - (i % 3), (i > 0 && i % 3 == 0));
      end
    end
  endtask

  task automatic test_en_toggle();
    int ec[5]  = '{5, 4, 4, 3, 3};
    bit enq[5] = '{1, 1, 0, 1, 0};
    load = 1'b1; load_val = 4'd5; auto_rl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = enq[i];
      step();
      load = 1'b0;
      total++; if (count !== NB'(ec[i]) || tc !== 1'b0) begin
        bad++; $display("FAIL en_toggle[%0d] count=%0d tc=%0b exp count=%0d tc=0", i, count, tc, ec[i]);
      end
    end
  endtask

  task automatic test_zero_load();
    bit et[3] = '{0, 1, 0};
    bit eb[3] = '{1, 0, 0};
    load = 1'b1; load_val = 4'd0; auto_rl = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      load = 1'b0;
      total++; if (count !== 4'd0 || tc !== et[i] || busy !== eb[i]) begin
        bad++; $display("FAIL zero_load[%0d] count=%0d tc=%0b busy=%0b exp count=0 tc=%0b busy=%0b",
                        i, count, tc, busy, et[i], eb[i]);
      end
    end
  endtask

  task automatic test_load_at_terminal();
    load = 1'b1; load_val = 4'd1; auto_rl = 1'b0; en = 1'b1;
    step();
    load = 1'b0;
    step();
    total++; if (count !== 4'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL lat_setup count=%0d busy=%0b exp count=0 busy=1", count, busy);
    end
    load = 1'b1; load_val = 4'd7;
    step();
    total++; if (count !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL load_at_terminal count=%0d tc=%0b busy=%0b exp count=7 tc=0 busy=1", count, tc, busy);
    end
    load = 1'b0; en = 1'b0;
    step();
    total++; if (count !== 4'd7 || tc !== 1'b0) begin
      bad++; $display("FAIL lat_hold count=%0d tc=%0b exp count=7 tc=0", count, tc);
    end
  endtask

  task automatic test_reset_midrun();
    load = 1'b1; load_val = 4'd6; auto_rl = 1'b1; en = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    total++; if (count !== 4'd4) begin bad++; $display("FAIL rmr_setup count=%0d exp=4", count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_midrun count=%0d tc=%0b busy=%0b exp 0 0 0", count, tc, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL no_restart[%0d] count=%0d tc=%0b busy=%0b exp 0 0 0", i, count, tc, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = NB'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      auto_rl  = ($urandom_range(0, 2) != 0);
      step();
      total++; if (count !== NB'(model_count()) || tc !== m_tc || busy !== m_running) begin
        bad++; $display("FAIL random[%0d] count=%0d tc=%0b busy=%0b exp count=%0d tc=%0b busy=%0b",
                        i, count, tc, busy, model_count(), m_tc, m_running);
      end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_en_toggle();
    test_zero_load();
    test_load_at_terminal();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
